// File: rtl/ultrasonic_ranger.sv
// HC-SR04-style ultrasonic ranger: issues a TRIG pulse, times the ECHO high pulse and
// reports the distance in UNIT_CYCLES-sized units, or all-ones with a timeout flag.
module ultrasonic_ranger #(
    parameter int unsigned DisLen      = 16,
    parameter int unsigned TRIG_CYCLES = 500,
    parameter int unsigned UNIT_CYCLES = 290,
    parameter int unsigned WAIT_MAX    = 100000,
    parameter int unsigned ECHO_MAX    = 1900000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trigger,
    input  logic            echo,
    output logic            triggerSuc,
    output logic            valid,
    output logic [DisLen:0] distance,
    output logic            timeout,
    output logic            trig_pin
);
    localparam int unsigned CntW = 21;
    localparam logic [CntW-1:0] TrigLen  = CntW'(TRIG_CYCLES);
    localparam logic [CntW-1:0] UnitLast = CntW'(UNIT_CYCLES - 1);
    localparam logic [CntW-1:0] WaitLast = CntW'(WAIT_MAX - 1);
    localparam logic [CntW-1:0] EchoLast = CntW'(ECHO_MAX - 1);
    localparam logic [DisLen:0] DistMax  = '1;

    typedef enum logic [2:0] {StIdle, StTrig, StWaitEcho, StEcho, StDone} state_e;

    state_e            r_state, w_state_d;
    logic              r_echo_meta, r_echo_s;
    logic [CntW-1:0]   r_cnt, w_cnt_d;
    logic [CntW-1:0]   r_unit, w_unit_d, w_unit_step;
    logic [DisLen:0]   r_acc, w_acc_d, w_acc_step;
    logic              r_to_flag, w_to_flag_d;
    logic              r_trig_pin, w_trig_pin_d;
    logic              r_trig_suc, w_trig_suc_d;
    logic              r_valid, w_valid_d;
    logic [DisLen:0]   r_distance, w_distance_d;
    logic              r_timeout, w_timeout_d;
    logic              w_unit_wrap;

    // One echo-high cycle worth of unit counting, with a saturating accumulator.
    assign w_unit_wrap = (r_unit == UnitLast);
    assign w_unit_step = w_unit_wrap ? '0 : r_unit + 1'b1;
    assign w_acc_step  = (w_unit_wrap && (r_acc != DistMax)) ? r_acc + 1'b1 : r_acc;

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_unit_d     = r_unit;
        w_acc_d      = r_acc;
        w_to_flag_d  = r_to_flag;
        w_trig_pin_d = 1'b0;
        w_trig_suc_d = 1'b0;
        w_valid_d    = 1'b0;
        w_distance_d = r_distance;
        w_timeout_d  = r_timeout;
        unique case (r_state)
            StIdle: begin
                if (trigger) begin
                    w_state_d   = StTrig;
                    w_cnt_d     = '0;
                    w_unit_d    = '0;
                    w_acc_d     = '0;
                    w_to_flag_d = 1'b0;
                end
            end
            StTrig: begin
                if (r_cnt == TrigLen) begin
                    w_trig_suc_d = 1'b1;
                    w_cnt_d      = '0;
                    w_state_d    = StWaitEcho;
                end else begin
                    w_trig_pin_d = 1'b1;
                    w_cnt_d      = r_cnt + 1'b1;
                end
            end
            StWaitEcho: begin
                // The cycle that detects echo high already counts as N = 1.
                if (r_echo_s) begin
                    w_state_d = StEcho;
                    w_cnt_d   = CntW'(1);
                    w_unit_d  = w_unit_step;
                    w_acc_d   = w_acc_step;
                end else if (r_cnt == WaitLast) begin
                    w_state_d   = StDone;
                    w_acc_d     = DistMax;
                    w_to_flag_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StEcho: begin
                if (!r_echo_s) begin
                    w_state_d = StDone;
                end else if (r_cnt == EchoLast) begin
                    w_state_d   = StDone;
                    w_acc_d     = DistMax;
                    w_to_flag_d = 1'b1;
                end else begin
                    w_cnt_d  = r_cnt + 1'b1;
                    w_unit_d = w_unit_step;
                    w_acc_d  = w_acc_step;
                end
            end
            StDone: begin
                w_valid_d    = 1'b1;
                w_distance_d = r_acc;
                w_timeout_d  = r_to_flag;
                w_state_d    = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
            r_cnt       <= '0;
            r_unit      <= '0;
            r_acc       <= '0;
            r_to_flag   <= 1'b0;
            r_trig_pin  <= 1'b0;
            r_trig_suc  <= 1'b0;
            r_valid     <= 1'b0;
            r_distance  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_echo_meta <= echo;
            r_echo_s    <= r_echo_meta;
            r_cnt       <= w_cnt_d;
            r_unit      <= w_unit_d;
            r_acc       <= w_acc_d;
            r_to_flag   <= w_to_flag_d;
            r_trig_pin  <= w_trig_pin_d;
            r_trig_suc  <= w_trig_suc_d;
            r_valid     <= w_valid_d;
            r_distance  <= w_distance_d;
            r_timeout   <= w_timeout_d;
        end
    end

    assign trig_pin   = r_trig_pin;
    assign triggerSuc = r_trig_suc;
    assign valid      = r_valid;
    assign distance   = r_distance;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger with scaled-down timing parameters and a cycle-level
// reference model of each measurement (pulse timing, distance, timeout, valid cycle).
module tb_ultrasonic_ranger;
    localparam int DisLen   = 6;
    localparam int TrigCyc  = 20;
    localparam int UnitCyc  = 10;
    localparam int WaitMax  = 300;
    localparam int EchoMax  = 2000;
    localparam int MaxDist  = (1 << (DisLen + 1)) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            trigger;
    logic            echo;
    logic            triggerSuc;
    logic            valid;
    logic [DisLen:0] distance;
    logic            timeout;
    logic            trig_pin;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int suc_cnt = 0, suc_cyc = 0;
    int val_cnt = 0, val_cyc = 0, val_dist = 0, val_to = 0;
    int pin_cnt = 0, pin_first = 0, pin_last = 0;
    logic pin_prev = 1'b0;

    ultrasonic_ranger #(
        .DisLen     (DisLen),
        .TRIG_CYCLES(TrigCyc),
        .UNIT_CYCLES(UnitCyc),
        .WAIT_MAX   (WaitMax),
        .ECHO_MAX   (EchoMax)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .trigger   (trigger),
        .echo      (echo),
        .triggerSuc(triggerSuc),
        .valid     (valid),
        .distance  (distance),
        .timeout   (timeout),
        .trig_pin  (trig_pin)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample and log output events away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (triggerSuc) begin
            suc_cnt++;
            suc_cyc = cyc;
        end
        if (valid) begin
            val_cnt++;
            val_cyc  = cyc;
            val_dist = int'(distance);
            val_to   = int'(timeout);
        end
        if (trig_pin) begin
            pin_cnt++;
            if (!pin_prev) pin_first = cyc;
            pin_last = cyc;
        end
        pin_prev = trig_pin;
    endtask

    // start: echo rise time relative to the trigger-sampling edge; len 0 = echo never rises.
    task automatic measure(input string tag, input int start, input int len, input bit tog,
                           input bit hold);
        int e0, c, t_exp, f, n, v_exp, d_exp, to_exp, s0, v0, p0, guard;
        s0 = suc_cnt;
        v0 = val_cnt;
        p0 = pin_cnt;
        trigger = 1'b1;
        tick();
        e0 = cyc;
        if (!hold) trigger = 1'b0;
        while (cyc < e0 + start) tick();
        c = cyc;
        if (len > 0) begin
            echo = 1'b1;
            for (int i = 0; i < len; i++) begin
                if (tog) trigger = (i < EchoMax - 10) ? i[2] : 1'b0;
                tick();
            end
            echo = 1'b0;
            if (tog) trigger = 1'b0;
        end
        guard = 0;
        while (val_cnt == v0 && guard < WaitMax + EchoMax + 100) begin
            tick();
            guard++;
        end
        repeat (4) tick();
        if (hold) trigger = 1'b0;

        t_exp = e0 + TrigCyc + 1;
        if (len == 0) begin
            to_exp = 1;
            d_exp  = MaxDist;
            v_exp  = t_exp + WaitMax + 1;
        end else begin
            // First edge the FSM can see echo high, and number of high cycles it counts.
            f = (c + 3 > t_exp + 1) ? c + 3 : t_exp + 1;
            n = c + len + 2 - f + 1;
            if (n >= EchoMax) begin
                to_exp = 1;
                d_exp  = MaxDist;
                v_exp  = f + EchoMax;
            end else begin
                to_exp = 0;
                d_exp  = (n / UnitCyc > MaxDist) ? MaxDist : n / UnitCyc;
                v_exp  = c + len + 4;
            end
        end

        check_eq({tag, "_suc_count"}, suc_cnt - s0, 1);
        check_eq({tag, "_suc_cycle"}, suc_cyc, t_exp);
        if (!hold) begin
            check_eq({tag, "_pin_first"}, pin_first, e0 + 1);
            check_eq({tag, "_pin_last"}, pin_last, e0 + TrigCyc);
            check_eq({tag, "_pin_len"}, pin_cnt - p0, TrigCyc);
        end
        check_eq({tag, "_valid_count"}, val_cnt - v0, 1);
        check_eq({tag, "_valid_cycle"}, val_cyc, v_exp);
        check_eq({tag, "_distance"}, val_dist, d_exp);
        check_eq({tag, "_timeout"}, val_to, to_exp);
    endtask

    initial begin
        int s1, v1, vv, guard, dly, len;
        rst     = 1'b1;
        trigger = 1'b0;
        echo    = 1'b0;
        #1;
        check_eq("rst_trig_pin", int'(trig_pin), 0);
        check_eq("rst_suc", int'(triggerSuc), 0);
        check_eq("rst_valid", int'(valid), 0);
        check_eq("rst_timeout", int'(timeout), 0);
        check_eq("rst_distance", int'(distance), 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        measure("d100", TrigCyc + 1 + 30, 100, 1'b0, 1'b0);
        measure("d109", TrigCyc + 1 + 7, 109, 1'b0, 1'b0);
        measure("d9", TrigCyc + 1, 9, 1'b0, 1'b0);
        measure("sat", TrigCyc + 1 + 2, 1500, 1'b0, 1'b0);
        measure("echo_max_m1", TrigCyc + 1 + 4, EchoMax - 1, 1'b0, 1'b0);
        measure("echo_max", TrigCyc + 1 + 4, EchoMax, 1'b0, 1'b0);
        measure("no_echo", TrigCyc + 1, 0, 1'b0, 1'b0);
        measure("stuck", TrigCyc + 1 + 11, EchoMax + 50, 1'b1, 1'b0);
        measure("pre_rise", TrigCyc - 9, 100, 1'b0, 1'b0);

        // Trigger held high across the result starts a fresh measurement.
        measure("hold", TrigCyc + 1 + 5, 50, 1'b0, 1'b1);
        s1 = suc_cnt;
        vv = val_cyc;
        guard = 0;
        while (suc_cnt == s1 && guard < TrigCyc + 10) begin
            tick();
            guard++;
        end
        check_eq("hold_resuc_count", suc_cnt - s1, 1);
        check_eq("hold_resuc_cycle", suc_cyc, vv + TrigCyc + 2);
        v1 = val_cnt;
        guard = 0;
        while (val_cnt == v1 && guard < WaitMax + 50) begin
            tick();
            guard++;
        end
        check_eq("hold_re_valid_cycle", val_cyc, suc_cyc + WaitMax + 1);
        check_eq("hold_re_timeout", val_to, 1);
        check_eq("hold_re_distance", val_dist, MaxDist);

        // Reset in the middle of the trigger pulse aborts the measurement.
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (10) tick();
        check_eq("mid_pin_high", int'(trig_pin), 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_pin", int'(trig_pin), 0);
        check_eq("mid_rst_distance", int'(distance), 0);
        check_eq("mid_rst_timeout", int'(timeout), 0);
        check_eq("mid_rst_valid", int'(valid), 0);
        s1 = suc_cnt;
        v1 = val_cnt;
        repeat (3) tick();
        rst = 1'b0;
        repeat (TrigCyc + WaitMax + 20) tick();
        check_eq("mid_rst_no_suc", suc_cnt - s1, 0);
        check_eq("mid_rst_no_valid", val_cnt - v1, 0);

        for (int k = 0; k < 8; k++) begin
            dly = int'($urandom_range(0, WaitMax - 4));
            len = int'($urandom_range(0, EchoMax + 100));
            measure("rnd", TrigCyc + 1 + dly, len, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
